pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: prioritised redirects, stall capture of one pending redirect, flush pulse timer.
// Optional: define PC_SEQ_REDIRECT_CNT_EN to add the saturating redirect_cnt output.
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              NUM_SRC   = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*PC_W-1:0] src_pc,
  output logic [PC_W-1:0]         pc,
  output logic                    flush,
  output logic                    redirect_taken,
  output logic                    pending
`ifdef PC_SEQ_REDIRECT_CNT_EN
  ,
  output logic [15:0]             redirect_cnt
`endif
);

  // state | meaning
  // RUN   | no captured redirect; pc advances or takes a live winner
  // HOLD  | a redirect captured during stall waits for stall release

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  pend_pc, pend_pc_nxt;
  logic [IDX_W-1:0] pend_idx, pend_idx_nxt;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [PC_W-1:0]  win_pc;
  logic             apply;
  logic [2:0]       flush_cnt, flush_cnt_nxt;

  // Scan from the top so the lowest valid index is the last one written.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_pc    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        win_pc    = src_pc[i*PC_W +: PC_W];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pc_nxt  = pend_pc;
    pend_idx_nxt = pend_idx;
    apply        = 1'b0;
    if (!stall) begin
      state_nxt = RUN;
      if (win_valid) begin
        pc_nxt = win_pc;
        apply  = 1'b1;
      end else if (state == HOLD) begin
        pc_nxt = pend_pc;
        apply  = 1'b1;
      end else begin
        pc_nxt = pc + PC_W'(1);
      end
    end else if (win_valid && (state == RUN || win_idx <= pend_idx)) begin
      // Equal index overwrites so the newest request from a channel wins.
      state_nxt    = HOLD;
      pend_pc_nxt  = win_pc;
      pend_idx_nxt = win_idx;
    end
  end

  always_comb begin
    flush_cnt_nxt = flush_cnt;
    if (apply) begin
      flush_cnt_nxt = 3'(FLUSH_CYC);
    end else if (flush_cnt != 3'd0) begin
      flush_cnt_nxt = flush_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pend_pc        <= '0;
      pend_idx       <= '0;
      flush_cnt      <= 3'd0;
      redirect_taken <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      pend_pc        <= pend_pc_nxt;
      pend_idx       <= pend_idx_nxt;
      flush_cnt      <= flush_cnt_nxt;
      redirect_taken <= apply;
    end
  end

  assign pending = (state == HOLD);
  assign flush   = (flush_cnt != 3'd0);

`ifdef PC_SEQ_REDIRECT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= 16'h0000;
    end else if (apply && redirect_cnt != 16'hFFFF) begin
      redirect_cnt <= redirect_cnt + 16'h0001;
    end
  end
`else
  // Redirect counter not built.
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
// Exercises redirect_cnt too when PC_SEQ_REDIRECT_CNT_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [3:0]  src_valid;
  logic [63:0] src_pc;
  logic [15:0] pc;
  logic        flush;
  logic        redirect_taken;
  logic        pending;
`ifdef PC_SEQ_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .src_valid      (src_valid),
    .src_pc         (src_pc),
    .pc             (pc),
    .flush          (flush),
    .redirect_taken (redirect_taken),
    .pending        (pending)
`ifdef PC_SEQ_REDIRECT_CNT_EN
    ,
    .redirect_cnt   (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [15:0] val);
    src_pc[idx*16 +: 16] = val;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; src_valid = 4'b1111; src_pc = 64'h4444_3333_2222_1111;
    step(); step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    checks++; if (redirect_taken !== 1'b0) begin errors++; $display("FAIL reset_rt: got %b expected 0", redirect_taken); end
`ifdef PC_SEQ_REDIRECT_CNT_EN
    checks++; if (redirect_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", redirect_cnt); end
`endif
  endtask

  task automatic test_sequential();
    reset = 1'b0; stall = 1'b0; src_valid = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (pc !== 16'(i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 16'(i)); end
    end
    checks++; if (flush !== 1'b0 || redirect_taken !== 1'b0) begin errors++; $display("FAIL seq_quiet: flush %b rt %b expected 0 0", flush, redirect_taken); end
    src_valid = 4'b0001; set_src(0, 16'hFFFF);
    step();
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_load: got %h expected ffff", pc); end
    src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", pc); end
  endtask

  task automatic test_priority();
    step(); step(); step();
    src_valid = 4'b1010; set_src(1, 16'h0040); set_src(3, 16'h0080);
    step();
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL prio_pc: got %h expected 0040", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush1: got %b expected 1", flush); end
    checks++; if (redirect_taken !== 1'b1) begin errors++; $display("FAIL prio_rt1: got %b expected 1", redirect_taken); end
    src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0041) begin errors++; $display("FAIL prio_next: got %h expected 0041", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL prio_flush2: got %b expected 1", flush); end
    checks++; if (redirect_taken !== 1'b0) begin errors++; $display("FAIL prio_rt2: got %b expected 0", redirect_taken); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL prio_flush3: got %b expected 0", flush); end
  endtask

  task automatic test_stall_capture();
    src_valid = 4'b0001; set_src(0, 16'h0050);
    step();
    src_valid = 4'b0000;
    step(); step(); step();
    checks++; if (pc !== 16'h0053 || flush !== 1'b0) begin errors++; $display("FAIL cap_base: pc %h flush %b expected 0053 0", pc, flush); end
    stall = 1'b1; src_valid = 4'b0100; set_src(2, 16'h0100);
    step();
    checks++; if (pc !== 16'h0053) begin errors++; $display("FAIL cap_hold: got %h expected 0053", pc); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL cap_pending: got %b expected 1", pending); end
    checks++; if (redirect_taken !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL cap_quiet: rt %b flush %b expected 0 0", redirect_taken, flush); end
    src_valid = 4'b1000; set_src(3, 16'h0200);
    step();
    checks++; if (pc !== 16'h0053 || pending !== 1'b1) begin errors++; $display("FAIL cap_keep: pc %h pending %b expected 0053 1", pc, pending); end
    stall = 1'b0; src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0100) begin errors++; $display("FAIL cap_release: got %h expected 0100", pc); end
    checks++; if (pending !== 1'b0 || redirect_taken !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL cap_release_flags: pending %b rt %b flush %b expected 0 1 1", pending, redirect_taken, flush); end
    stall = 1'b1;
    step();
    checks++; if (pc !== 16'h0100 || flush !== 1'b1 || redirect_taken !== 1'b0) begin errors++; $display("FAIL stall_flush1: pc %h flush %b rt %b expected 0100 1 0", pc, flush, redirect_taken); end
    step();
    checks++; if (flush !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL stall_flush0: flush %b pending %b expected 0 0", flush, pending); end
    src_valid = 4'b0100; set_src(2, 16'h0500);
    step();
    src_valid = 4'b0010; set_src(1, 16'h0600);
    step();
    set_src(1, 16'h0700);
    step();
    src_valid = 4'b0100; set_src(2, 16'h0800);
    step();
    checks++; if (pc !== 16'h0100 || pending !== 1'b1) begin errors++; $display("FAIL ovr_hold: pc %h pending %b expected 0100 1", pc, pending); end
    stall = 1'b0; src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0700) begin errors++; $display("FAIL ovr_release: got %h expected 0700", pc); end
  endtask

  task automatic test_release_overwrite();
    stall = 1'b1; src_valid = 4'b0100; set_src(2, 16'h0100);
    step();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rel_pending: got %b expected 1", pending); end
    stall = 1'b0; src_valid = 4'b0001; set_src(0, 16'h0300);
    step();
    checks++; if (pc !== 16'h0300 || pending !== 1'b0 || redirect_taken !== 1'b1) begin errors++; $display("FAIL rel_win: pc %h pending %b rt %b expected 0300 0 1", pc, pending, redirect_taken); end
    src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0301 || pending !== 1'b0) begin errors++; $display("FAIL rel_cleared: pc %h pending %b expected 0301 0", pc, pending); end
  endtask

  task automatic test_flush_restart();
    step(); step(); step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fr_idle: got %b expected 0", flush); end
    src_valid = 4'b0001; set_src(0, 16'h1000);
    step();
    checks++; if (pc !== 16'h1000 || flush !== 1'b1) begin errors++; $display("FAIL fr_t1: pc %h flush %b expected 1000 1", pc, flush); end
    set_src(0, 16'h2000);
    step();
    checks++; if (pc !== 16'h2000 || flush !== 1'b1 || redirect_taken !== 1'b1) begin errors++; $display("FAIL fr_t2: pc %h flush %b rt %b expected 2000 1 1", pc, flush, redirect_taken); end
    src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h2001 || flush !== 1'b1 || redirect_taken !== 1'b0) begin errors++; $display("FAIL fr_t3: pc %h flush %b rt %b expected 2001 1 0", pc, flush, redirect_taken); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fr_t4: got %b expected 0", flush); end
  endtask

  task automatic test_reset_hold();
    stall = 1'b0; src_valid = 4'b0001; set_src(0, 16'h0A00);
    step();
    stall = 1'b1; set_src(0, 16'h3000);
    step();
    checks++; if (pending !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL rh_pre: pending %b flush %b expected 1 1", pending, flush); end
    reset = 1'b1;
    step();
    checks++; if (pc !== 16'h0000 || pending !== 1'b0 || flush !== 1'b0 || redirect_taken !== 1'b0) begin errors++; $display("FAIL rh_reset: pc %h pending %b flush %b rt %b expected 0000 0 0 0", pc, pending, flush, redirect_taken); end
`ifdef PC_SEQ_REDIRECT_CNT_EN
    checks++; if (redirect_cnt !== 16'h0000) begin errors++; $display("FAIL rh_cnt0: got %h expected 0000", redirect_cnt); end
`endif
    reset = 1'b0; stall = 1'b0; src_valid = 4'b0000;
    step();
    checks++; if (pc !== 16'h0001 || pending !== 1'b0 || redirect_taken !== 1'b0) begin errors++; $display("FAIL rh_after: pc %h pending %b rt %b expected 0001 0 0", pc, pending, redirect_taken); end
`ifdef PC_SEQ_REDIRECT_CNT_EN
    src_valid = 4'b0001; set_src(0, 16'h1234);
    step(); step(); step();
    checks++; if (redirect_cnt !== 16'h0003) begin errors++; $display("FAIL cnt3: got %h expected 0003", redirect_cnt); end
    for (int i = 0; i < 69997; i++) step();
    checks++; if (redirect_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h expected ffff", redirect_cnt); end
    src_valid = 4'b0000;
`endif
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; src_valid = 4'b0000; src_pc = '0;
    #1;
    test_reset();
    test_sequential();
    test_priority();
    test_stall_capture();
    test_release_overwrite();
    test_flush_restart();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
